// File: rtl/snitch_tcdm_resp_buffer.sv
// rtl/snitch_tcdm_resp_buffer.sv - credit-gated TCDM request forwarder with in-order response buffer
// Reads are admitted only while a response slot is guaranteed; writes always pass through.

package snitch_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  strb;
  } dreq_t;

  typedef struct packed {
    logic [31:0] data;
  } dresp_t;
endpackage

module snitch_tcdm_resp_buffer #(
  parameter type         req_t     = snitch_pkg::dreq_t,
  parameter type         resp_t    = snitch_pkg::dresp_t,
  parameter int unsigned RespDepth = 8,
  parameter int unsigned CntWidth  = $clog2(RespDepth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  req_t                req_payload_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output resp_t               resp_payload_o,
  output logic                resp_last_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output req_t                mem_req_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  input  resp_t               mem_rsp_i,
  input  logic                mem_rvalid_i,
  output logic [CntWidth-1:0] credits_used_o,
  output logic                err_o
);

  localparam int unsigned         PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(RespDepth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(RespDepth - 1);

  logic [CntWidth-1:0] used_q;
  logic [CntWidth-1:0] occ_q;
  logic [CntWidth-1:0] outstanding;
  logic [PtrWidth-1:0] wptr_q;
  logic [PtrWidth-1:0] rptr_q;
  logic                err_q;
  resp_t               buf_q [RespDepth];

  logic credit_ok;
  logic admit;
  logic rd_hs;
  logic pop;
  logic push;
  logic full;
  logic stray;
  logic overflow;

  // Admission looks only at the registered count, so resp_ready_i never reaches the request side.
  assign credit_ok   = used_q < DepthCnt;
  assign admit       = req_payload_i.write | credit_ok;
  assign mem_valid_o = req_valid_i & admit;
  assign req_ready_o = mem_ready_i & admit;
  assign mem_req_o   = req_payload_i;

  assign rd_hs        = mem_valid_o & mem_ready_i & ~req_payload_i.write;
  assign resp_valid_o = occ_q != '0;
  assign pop          = resp_valid_o & resp_ready_i;
  assign full         = occ_q == DepthCnt;
  assign outstanding  = used_q - occ_q;

  // Beats with no read in flight, or with nowhere to go, are dropped and flagged.
  assign stray    = mem_rvalid_i & (outstanding == '0);
  assign overflow = mem_rvalid_i & full & ~pop;
  assign push     = mem_rvalid_i & ~stray & ~overflow;

  assign resp_payload_o = buf_q[rptr_q];
  assign resp_last_o    = 1'b1;
  assign credits_used_o = used_q;
  assign err_o          = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      used_q <= '0;
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (rd_hs && !pop) begin
        used_q <= used_q + CntWidth'(1);
      end else if (!rd_hs && pop) begin
        used_q <= used_q - CntWidth'(1);
      end

      if (push && !pop) begin
        occ_q <= occ_q + CntWidth'(1);
      end else if (!push && pop) begin
        occ_q <= occ_q - CntWidth'(1);
      end

      if (push) begin
        wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
      end

      err_q <= err_q | stray | overflow;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wptr_q] <= mem_rsp_i;
    end
  end

endmodule

// File: tb/tb_snitch_tcdm_resp_buffer.sv
// tb/tb_snitch_tcdm_resp_buffer.sv - scoreboard bench for snitch_tcdm_resp_buffer
// Stimulus pushes expected read data; a monitor pops and compares on every response pop.

module tb_snitch_tcdm_resp_buffer;

  localparam int unsigned Depth = 3;
  localparam int unsigned CW    = $clog2(Depth + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  snitch_pkg::dreq_t  req;
  logic               req_valid;
  logic               req_ready;
  snitch_pkg::dresp_t resp_payload;
  logic               resp_last;
  logic               resp_valid;
  logic               resp_ready;
  snitch_pkg::dreq_t  mem_req;
  logic               mem_valid;
  logic               mem_ready;
  snitch_pkg::dresp_t mem_rsp;
  logic               mem_rvalid;
  logic [CW-1:0]      credits;
  logic               err;

  int          checks  = 0;
  int          errors  = 0;
  logic [31:0] exp_q[$];
  int          lat     = 1;
  int          inj_cnt = 0;
  bit          rand_mode = 1'b0;

  always #5 clk = ~clk;

  snitch_tcdm_resp_buffer #(
    .req_t    (snitch_pkg::dreq_t),
    .resp_t   (snitch_pkg::dresp_t),
    .RespDepth(Depth)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_payload_i (req),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .resp_payload_o(resp_payload),
    .resp_last_o   (resp_last),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .mem_req_o     (mem_req),
    .mem_valid_o   (mem_valid),
    .mem_ready_i   (mem_ready),
    .mem_rsp_i     (mem_rsp),
    .mem_rvalid_i  (mem_rvalid),
    .credits_used_o(credits),
    .err_o         (err)
  );

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      mem_ready  = 1'($urandom_range(0, 1));
      resp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, output int stalls);
    req.addr  = addr;
    req.write = wr;
    req.data  = ~addr;
    req.strb  = 4'hF;
    req_valid = 1'b1;
    stalls    = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      stalls++;
      if (stalls > 200) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: addr %0h never granted", addr);
        break;
      end
      step();
    end
    if (req_ready) begin
      chk("mem_req_pass", 32'(mem_req == req), 32'd1);
      if (!wr) exp_q.push_back(rd_data(addr));
    end
    step();
    req_valid = 1'b0;
  endtask

  // Memory: fixed-latency in-order read responses, plus on-demand stray beats.
  initial begin : mem_model
    int          cyc;
    int          inj_done;
    int          due_q[$];
    logic [31:0] dat_q[$];
    cyc        = 0;
    inj_done   = 0;
    mem_rvalid = 1'b0;
    mem_rsp    = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_valid && mem_ready && !mem_req.write) begin
        due_q.push_back(cyc + lat);
        dat_q.push_back(rd_data(mem_req.addr));
      end
      @(posedge clk);
      cyc++;
      #1;
      mem_rvalid = 1'b0;
      if (inj_cnt != inj_done) begin
        inj_done     = inj_cnt;
        mem_rvalid   = 1'b1;
        mem_rsp.data = 32'hDEAD_BEEF;
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        mem_rsp.data = dat_q.pop_front();
        mem_rvalid   = 1'b1;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (credits > CW'(Depth)) begin
          errors++;
          $display("FAIL credit_bound: got %0d limit %0d", credits, Depth);
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got %0h expected no response", resp_payload.data);
          end else begin
            chk("resp_data", resp_payload.data, exp_q.pop_front());
            chk("resp_last", 32'(resp_last), 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int st;
    int total;
    req        = '0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    mem_ready  = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_credits", 32'(credits), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_last", 32'(resp_last), 32'd1);
    rst = 1'b0;
    step();

    // Single read, latency 1
    issue(32'h10, 1'b0, st);
    chk("single_stall", 32'(st), 32'd0);
    @(negedge clk);
    chk("single_c1_credits", 32'(credits), 32'd1);
    chk("single_c1_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("single_c2_credits", 32'(credits), 32'd1);
    chk("single_c2_valid", 32'(resp_valid), 32'd1);
    chk("single_c2_last", 32'(resp_last), 32'd1);
    @(negedge clk);
    chk("single_c3_credits", 32'(credits), 32'd0);
    chk("single_c3_valid", 32'(resp_valid), 32'd0);
    step();

    // Credit exhaustion, then write bypass
    resp_ready = 1'b0;
    issue(32'h20, 1'b0, st);
    issue(32'h24, 1'b0, st);
    issue(32'h28, 1'b0, st);
    req.addr  = 32'h30;
    req.write = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    chk("wr_credits_full", 32'(credits), 32'd3);
    chk("wr_mem_valid", 32'(mem_valid), 32'd1);
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_credits_same", 32'(credits), 32'd3);
    step();
    req.addr  = 32'h2C;
    req.write = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("exh_req_ready", 32'(req_ready), 32'd0);
    chk("exh_mem_valid", 32'(mem_valid), 32'd0);
    chk("exh_buffered", 32'(resp_valid), 32'd1);
    step();
    resp_ready = 1'b1;
    @(negedge clk);
    chk("exh_pop_cycle_ready", 32'(req_ready), 32'd0);
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    chk("exh_release_ready", 32'(req_ready), 32'd1);
    chk("exh_release_valid", 32'(mem_valid), 32'd1);
    exp_q.push_back(rd_data(32'h2C));
    step();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (6) step();
    chk("exh_drain_credits", 32'(credits), 32'd0);
    chk("exh_drain_queue", 32'(exp_q.size()), 32'd0);

    // Streaming: depth 3 covers latency 1 at full rate
    total = 0;
    for (int i = 0; i < 40; i++) begin
      issue(32'h1000 + 32'(4 * i), 1'b0, st);
      total += st;
    end
    repeat (6) step();
    chk("stream_stalls", 32'(total), 32'd0);
    chk("stream_err", 32'(err), 32'd0);
    chk("stream_queue", 32'(exp_q.size()), 32'd0);

    // Random back-pressure with wrap-around, latency 2, mixed writes
    rand_mode = 1'b1;
    lat       = 2;
    for (int i = 0; i < 30; i++) begin
      issue(32'h2000 + 32'(4 * i), (i % 5) == 3, st);
    end
    rand_mode  = 1'b0;
    mem_ready  = 1'b1;
    resp_ready = 1'b1;
    repeat (12) step();
    chk("rand_queue", 32'(exp_q.size()), 32'd0);
    chk("rand_credits", 32'(credits), 32'd0);
    chk("rand_err", 32'(err), 32'd0);
    lat = 1;

    // Stray response sets the sticky error and is dropped
    @(negedge clk);
    inj_cnt++;
    @(posedge clk);
    @(negedge clk);
    chk("stray_rvalid", 32'(mem_rvalid), 32'd1);
    chk("stray_err_before", 32'(err), 32'd0);
    @(negedge clk);
    chk("stray_err_after", 32'(err), 32'd1);
    chk("stray_fifo_empty", 32'(resp_valid), 32'd0);
    chk("stray_credits", 32'(credits), 32'd0);
    step();

    // Reset mid-stream discards buffered responses immediately
    resp_ready = 1'b0;
    issue(32'h3000, 1'b0, st);
    issue(32'h3004, 1'b0, st);
    repeat (3) step();
    chk("mid_buffered", 32'(resp_valid), 32'd1);
    chk("mid_credits", 32'(credits), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_credits", 32'(credits), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    step();
    step();
    rst        = 1'b0;
    resp_ready = 1'b1;
    step();
    issue(32'h4000, 1'b0, st);
    repeat (5) step();
    chk("post_rst_queue", 32'(exp_q.size()), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_credits", 32'(credits), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
